// File: rtl/mymod_sweep_ctrl.sv
// ---------------------------------------------------------------------------
// mymod_sweep_ctrl
//
// This module sequences one myMod datapath instance through a programmed sweep.
// It replaces the loop that a bench would otherwise run.
//
// When a start pulse arrives, the controller walks A from a_first to a_last
// (inclusive). The walk wraps modulo 2^A_W. For every A value it steps the
// mode {S,I} through 00, 01, 10, 11.
//
// Each {A,S,I} setting is held for HOLD_CYCLES clocks. After that, myMod's B
// output is captured. The captured value is offered on a valid/ready result
// port together with the A value and mode that produced it.
//
// Optional feature (compile-time macro SWEEP_CHECKSUM_EN):
//   When the macro is defined, an extra 16-bit output `checksum` appears.
//   - It is cleared on reset and on every accepted start.
//   - It accumulates res_data on each result handshake, modulo 2^16.
//   - Its final value is valid in the done cycle and is held until the next
//     start.
//   When the macro is undefined, neither the port nor the logic exists.
//
// Parameters
//   HOLD_CYCLES  clocks each setting is held before B is sampled (>=1)
//   A_W          width of A and of the sweep bounds
//   B_W          width of B and of the result data
//
// Ports
//   Clk        in   1    single clock, rising edge
//   Rst_n      in   1    synchronous active-low reset
//   start      in   1    one-cycle pulse; latches bounds; ignored while busy
//   a_first    in   A_W  first A value of the sweep
//   a_last     in   A_W  last A value of the sweep (inclusive)
//   busy       out  1    high from the cycle after an accepted start until done
//   done       out  1    one-cycle pulse after the last result handshake
//   mod_A      out  A_W  drives myMod A
//   mod_S      out  1    drives myMod S (mode[1])
//   mod_I      out  1    drives myMod I (mode[0])
//   mod_B      in   B_W  myMod B
//   res_valid  out  1    result available
//   res_ready  in   1    consumer accepts the result
//   res_data   out  B_W  captured B
//   res_a      out  A_W  A value that produced res_data
//   res_mode   out  2    {S,I} that produced res_data
//   checksum   out  16   running sum of accepted res_data (SWEEP_CHECKSUM_EN)
// ---------------------------------------------------------------------------
module mymod_sweep_ctrl #(
   parameter int HOLD_CYCLES = 8,
   parameter int A_W         = 5,
   parameter int B_W         = 8
) (
   input  logic           Clk,
   input  logic           Rst_n,
   input  logic           start,
   input  logic [A_W-1:0] a_first,
   input  logic [A_W-1:0] a_last,
   output logic           busy,
   output logic           done,
   output logic [A_W-1:0] mod_A,
   output logic           mod_S,
   output logic           mod_I,
   input  logic [B_W-1:0] mod_B,
   output logic           res_valid,
   input  logic           res_ready,
   output logic [B_W-1:0] res_data,
   output logic [A_W-1:0] res_a,
   output logic [1:0]     res_mode
`ifdef SWEEP_CHECKSUM_EN
   ,
   output logic [15:0]    checksum
`endif
);

   // The hold counter only needs to reach HOLD_CYCLES-1.
   // Its width is forced to at least one bit so that HOLD_CYCLES==1 still
   // produces a legal vector.
   localparam int               CNT_W     = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
   localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_APPLY,
      ST_OUT,
      ST_FIN
   } state_t;

   state_t           state_q,    state_d;
   logic [A_W-1:0]   aLast_q,    aLast_d;
   logic [A_W-1:0]   modA_q,     modA_d;
   logic [1:0]       mode_q,     mode_d;
   logic [CNT_W-1:0] holdCnt_q,  holdCnt_d;
   logic             busy_q,     busy_d;
   logic             resValid_q, resValid_d;
   logic [B_W-1:0]   resData_q,  resData_d;
   logic [A_W-1:0]   resA_q,     resA_d;
   logic [1:0]       resMode_q,  resMode_d;
`ifdef SWEEP_CHECKSUM_EN
   logic [15:0]      checksum_q, checksum_d;
`endif

   logic handshake;
   logic lastPoint;

   // A result is consumed only when the controller is actually offering one.
   // So a res_ready that arrives while nothing is valid is simply ignored.
   assign handshake = resValid_q && res_ready;

   // The sweep ends after the fourth mode of the last A value.
   // Only the end bound is kept: the start bound is consumed when the sweep
   // is launched.
   assign lastPoint = (modA_q == aLast_q) && (mode_q == 2'b11);

   // State register and all datapath registers.
   // Reset is synchronous. It returns every output to zero and abandons any
   // sweep in progress without producing a done pulse.
   always_ff @(posedge Clk) begin
      if (!Rst_n) begin
         state_q    <= ST_IDLE;
         aLast_q    <= '0;
         modA_q     <= '0;
         mode_q     <= '0;
         holdCnt_q  <= '0;
         busy_q     <= 1'b0;
         resValid_q <= 1'b0;
         resData_q  <= '0;
         resA_q     <= '0;
         resMode_q  <= '0;
`ifdef SWEEP_CHECKSUM_EN
         checksum_q <= '0;
`endif
      end else begin
         state_q    <= state_d;
         aLast_q    <= aLast_d;
         modA_q     <= modA_d;
         mode_q     <= mode_d;
         holdCnt_q  <= holdCnt_d;
         busy_q     <= busy_d;
         resValid_q <= resValid_d;
         resData_q  <= resData_d;
         resA_q     <= resA_d;
         resMode_q  <= resMode_d;
`ifdef SWEEP_CHECKSUM_EN
         checksum_q <= checksum_d;
`endif
      end
   end

   // Next-state and datapath update logic.
   // Every register holds its value unless the current state explicitly
   // changes it. This keeps mod_* and res_* rock-steady across stalls and
   // after the sweep finishes.
   always_comb begin
      state_d    = state_q;
      aLast_d    = aLast_q;
      modA_d     = modA_q;
      mode_d     = mode_q;
      holdCnt_d  = holdCnt_q;
      busy_d     = busy_q;
      resValid_d = resValid_q;
      resData_d  = resData_q;
      resA_d     = resA_q;
      resMode_d  = resMode_q;
`ifdef SWEEP_CHECKSUM_EN
      checksum_d = checksum_q;
`endif

      unique case (state_q)
         ST_IDLE: begin
            if (start) begin
               aLast_d   = a_last;
               modA_d    = a_first;
               mode_d    = 2'b00;
               holdCnt_d = '0;
               busy_d    = 1'b1;
`ifdef SWEEP_CHECKSUM_EN
               checksum_d = '0;
`endif
               state_d   = ST_APPLY;
            end
         end

         ST_APPLY: begin
            // B is sampled on the edge that closes the HOLD_CYCLES-th clock
            // of this setting. That gives myMod the full hold time to settle.
            if (holdCnt_q == HOLD_LAST) begin
               resData_d  = mod_B;
               resA_d     = modA_q;
               resMode_d  = mode_q;
               resValid_d = 1'b1;
               holdCnt_d  = '0;
               state_d    = ST_OUT;
            end else begin
               holdCnt_d = holdCnt_q + CNT_W'(1);
            end
         end

         ST_OUT: begin
            // The next setting is loaded on the handshake edge itself.
            // The first APPLY cycle therefore already drives it, so a
            // consumer that keeps ready high gets one result every
            // HOLD_CYCLES+1 clocks.
            if (handshake) begin
               resValid_d = 1'b0;
               holdCnt_d  = '0;
`ifdef SWEEP_CHECKSUM_EN
               checksum_d = checksum_q + 16'(resData_q);
`endif
               if (lastPoint) begin
                  state_d = ST_FIN;
               end else begin
                  if (mode_q == 2'b11) begin
                     mode_d = 2'b00;
                     modA_d = modA_q + A_W'(1);
                  end else begin
                     mode_d = mode_q + 2'd1;
                  end
                  state_d = ST_APPLY;
               end
            end
         end

         ST_FIN: begin
            busy_d  = 1'b0;
            state_d = ST_IDLE;
         end

         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   assign busy      = busy_q;
   assign done      = (state_q == ST_FIN);
   assign mod_A     = modA_q;
   assign mod_S     = mode_q[1];
   assign mod_I     = mode_q[0];
   assign res_valid = resValid_q;
   assign res_data  = resData_q;
   assign res_a     = resA_q;
   assign res_mode  = resMode_q;
`ifdef SWEEP_CHECKSUM_EN
   assign checksum  = checksum_q;
`endif

endmodule

// File: tb/tb_mymod_sweep_ctrl.sv
// ---------------------------------------------------------------------------
// tb_mymod_sweep_ctrl
//
// Bench for mymod_sweep_ctrl.
//
// A small behavioural stand-in for myMod produces B from the driven {A,S,I}
// with one clock of latency. When a sweep is launched, the expected stream of
// (A, mode, B) results is queued. Each result handshake pops the queue and
// compares against it.
//
// A table of sweeps covers these cases:
//   - full range
//   - single point
//   - wrap-around
//   - random backpressure with spurious starts
//   - a short sweep
// Hand-written sequences cover reset before and during a sweep.
// ---------------------------------------------------------------------------
module tb_mymod_sweep_ctrl;

   localparam int HOLD = 8;
   localparam int AW   = 5;
   localparam int BW   = 8;

   logic          Clk = 1'b0;
   logic          Rst_n = 1'b0;
   logic          start = 1'b0;
   logic [AW-1:0] a_first = '0;
   logic [AW-1:0] a_last = '0;
   logic          busy;
   logic          done;
   logic [AW-1:0] mod_A;
   logic          mod_S;
   logic          mod_I;
   logic [BW-1:0] modB = '0;
   logic          res_valid;
   logic          res_ready = 1'b0;
   logic [BW-1:0] res_data;
   logic [AW-1:0] res_a;
   logic [1:0]    res_mode;
`ifdef SWEEP_CHECKSUM_EN
   logic [15:0]   checksum;
`endif

   typedef struct {
      logic [AW-1:0] a;
      logic [1:0]    m;
      logic [BW-1:0] d;
   } expT;

   typedef struct {
      logic [AW-1:0] first;
      logic [AW-1:0] last;
      bit            randReady;
      bit            timing;
      bit            spurious;
      int            expCount;
   } vecT;

   expT           sb[$];
   int            nCompared = 0;
   int            nMismatched = 0;
   int            cycle = 0;
   int            doneCount = 0;
   int            resultCount = 0;
   int            lastHs = -1;
   logic [15:0]   sumModel = '0;
   bit            readyRandom = 1'b0;
   bit            timingCheck = 1'b0;
   bit            stallPrev = 1'b0;
   logic [BW-1:0] prevData;
   logic [AW-1:0] prevA;
   logic [1:0]    prevMode;
   logic [AW-1:0] prevModA;
   logic          prevModS;
   logic          prevModI;
   vecT           vecs[6];

   mymod_sweep_ctrl #(
      .HOLD_CYCLES(HOLD),
      .A_W        (AW),
      .B_W        (BW)
   ) dut (
      .Clk      (Clk),
      .Rst_n    (Rst_n),
      .start    (start),
      .a_first  (a_first),
      .a_last   (a_last),
      .busy     (busy),
      .done     (done),
      .mod_A    (mod_A),
      .mod_S    (mod_S),
      .mod_I    (mod_I),
      .mod_B    (modB),
      .res_valid(res_valid),
      .res_ready(res_ready),
      .res_data (res_data),
      .res_a    (res_a),
      .res_mode (res_mode)
`ifdef SWEEP_CHECKSUM_EN
      ,
      .checksum (checksum)
`endif
   );

   always #5 Clk = ~Clk;

   // Behavioural myMod: any deterministic map from {A,S,I} to B will do.
   // The map used here makes every (A, mode) pair give a distinct-looking
   // value.
   function automatic logic [BW-1:0] modelB(input logic [AW-1:0] a, input logic [1:0] m);
      return ({3'b000, a} * 8'd7) + ({6'b000000, m} * 8'd53) + 8'h11;
   endfunction

   // myMod answers one clock after its inputs change.
   // A capture taken too early would therefore see a stale value.
   always @(posedge Clk) modB <= modelB(mod_A, {mod_S, mod_I});

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      nCompared++;
      if (act !== exp) begin
         nMismatched++;
         $display("[TB] FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cycle);
      end
   endtask

   task automatic checkAllZero(input string tag);
      checkOutput({tag, ".busy"},      32'(busy),      0);
      checkOutput({tag, ".done"},      32'(done),      0);
      checkOutput({tag, ".res_valid"}, 32'(res_valid), 0);
      checkOutput({tag, ".mod_A"},     32'(mod_A),     0);
      checkOutput({tag, ".mod_S"},     32'(mod_S),     0);
      checkOutput({tag, ".mod_I"},     32'(mod_I),     0);
      checkOutput({tag, ".res_data"},  32'(res_data),  0);
      checkOutput({tag, ".res_a"},     32'(res_a),     0);
      checkOutput({tag, ".res_mode"},  32'(res_mode),  0);
`ifdef SWEEP_CHECKSUM_EN
      checkOutput({tag, ".checksum"},  32'(checksum),  0);
`endif
   endtask

   // Queue the full expected result stream of a sweep, in order.
   task automatic pushSweep(input logic [AW-1:0] first, input logic [AW-1:0] last);
      logic [AW-1:0] a;
      expT           e;
      int            nPts;
      a    = first;
      nPts = int'(AW'(last - first)) + 1;
      for (int p = 0; p < nPts; p++) begin
         for (int m = 0; m < 4; m++) begin
            e.a = a;
            e.m = 2'(m);
            e.d = modelB(a, 2'(m));
            sb.push_back(e);
         end
         a = a + AW'(1);
      end
   endtask

   // Result monitor. It runs on the falling edge, away from the DUT's active
   // edge. It decides res_ready for the coming edge. Whenever valid and
   // ready coincide, it pops the scoreboard and compares.
   always @(negedge Clk) begin
      expT e;
      bit  readyNow;
      cycle++;
      if (!Rst_n) begin
         stallPrev = 1'b0;
         res_ready = 1'b0;
         lastHs    = -1;
         sumModel  = '0;
      end else begin
         if (stallPrev) begin
            checkOutput("stallValid",    32'(res_valid), 1);
            checkOutput("stallData",     32'(res_data),  32'(prevData));
            checkOutput("stallResA",     32'(res_a),     32'(prevA));
            checkOutput("stallResMode",  32'(res_mode),  32'(prevMode));
            checkOutput("stallModA",     32'(mod_A),     32'(prevModA));
            checkOutput("stallModS",     32'(mod_S),     32'(prevModS));
            checkOutput("stallModI",     32'(mod_I),     32'(prevModI));
         end
         if (done) begin
            doneCount++;
            checkOutput("doneQueueEmpty", 32'(sb.size()), 0);
            checkOutput("doneNoValid",    32'(res_valid), 0);
`ifdef SWEEP_CHECKSUM_EN
            checkOutput("checksumAtDone", 32'(checksum), 32'(sumModel));
`endif
            lastHs   = -1;
            sumModel = '0;
         end
         readyNow  = readyRandom ? ($urandom_range(0, 9) < 3) : 1'b1;
         res_ready = readyNow;
         if (res_valid && readyNow) begin
            checkOutput("resultExpected", 32'(sb.size() > 0), 1);
            if (sb.size() > 0) begin
               e = sb.pop_front();
               checkOutput("resA",    32'(res_a),    32'(e.a));
               checkOutput("resMode", 32'(res_mode), 32'(e.m));
               checkOutput("resData", 32'(res_data), 32'(e.d));
               sumModel = sumModel + 16'(e.d);
            end
            resultCount++;
            if (timingCheck) begin
               if (lastHs >= 0) checkOutput("resultInterval", 32'(cycle - lastHs), HOLD + 1);
               lastHs = cycle;
            end
         end
         stallPrev = res_valid && !readyNow;
         prevData  = res_data;
         prevA     = res_a;
         prevMode  = res_mode;
         prevModA  = mod_A;
         prevModS  = mod_S;
         prevModI  = mod_I;
      end
   end

   // Launch one sweep and follow it to done. The wait is bounded.
   // While the sweep runs, the bounds are scrambled; that change must be
   // ignored. Optionally, spurious starts are thrown in; they must be ignored
   // too.
   task automatic applyStimulus(input vecT v);
      int  doneBase;
      int  resBase;
      bit  finished;
      doneBase    = doneCount;
      resBase     = resultCount;
      readyRandom = v.randReady;
      timingCheck = v.timing;
      pushSweep(v.first, v.last);
      @(posedge Clk); #1;
      a_first = v.first;
      a_last  = v.last;
      start   = 1'b1;
      @(posedge Clk); #1;
      start   = 1'b0;
      checkOutput("busyAfterStart", 32'(busy), 1);
      a_first = ~v.first;
      a_last  = ~v.last;
      finished = 1'b0;
      for (int w = 0; w < 6000 && !finished; w++) begin
         @(posedge Clk); #1;
         start = 1'b0;
         if (doneCount != doneBase) begin
            finished = 1'b1;
         end else if (v.spurious && busy && $urandom_range(0, 9) == 0) begin
            start   = 1'b1;
            a_first = AW'($urandom);
            a_last  = AW'($urandom);
         end
      end
      start = 1'b0;
      checkOutput("sweepFinished", 32'(finished), 1);
      checkOutput("resultCount",   32'(resultCount - resBase), 32'(v.expCount));
      checkOutput("busyAfterDone", 32'(busy), 0);
      repeat (5) @(posedge Clk);
      #1;
      checkOutput("singleDone", 32'(doneCount - doneBase), 1);
      checkOutput("idleNoValid", 32'(res_valid), 0);
      sb.delete();
   endtask

   initial begin
      int resBase;
      int doneBase;

      //         first  last   rand  timing spur  count
      vecs[0] = '{5'd7,  5'd7,  1'b0, 1'b1, 1'b0,   4};
      vecs[1] = '{5'd0,  5'd31, 1'b0, 1'b1, 1'b0, 128};
      vecs[2] = '{5'd30, 5'd1,  1'b0, 1'b1, 1'b0,  16};
      vecs[3] = '{5'd3,  5'd10, 1'b1, 1'b0, 1'b1,  32};
      vecs[4] = '{5'd0,  5'd3,  1'b0, 1'b1, 1'b0,  16};
      vecs[5] = '{5'd31, 5'd0,  1'b1, 1'b0, 1'b1,   8};

      // Power-on reset: every output must be zero.
      Rst_n = 1'b0;
      repeat (2) @(posedge Clk);
      #1;
      checkAllZero("reset");
      Rst_n = 1'b1;

      // Reset in the middle of APPLY, after two results have been handed
      // out. There is one result every nine clocks, so 25 edges after the
      // start edge lands inside the third hold window.
      readyRandom = 1'b0;
      timingCheck = 1'b1;
      resBase     = resultCount;
      doneBase    = doneCount;
      pushSweep(5'd5, 5'd9);
      @(posedge Clk); #1;
      a_first = 5'd5;
      a_last  = 5'd9;
      start   = 1'b1;
      @(posedge Clk); #1;
      start   = 1'b0;
      repeat (25) @(posedge Clk);
      #1;
      checkOutput("preResetResults", 32'(resultCount - resBase), 2);
      checkOutput("preResetBusy",    32'(busy), 1);
      Rst_n = 1'b0;
      repeat (2) @(posedge Clk);
      #1;
      checkAllZero("midReset");
      checkOutput("noDoneOnAbort", 32'(doneCount - doneBase), 0);
      sb.delete();
      Rst_n = 1'b1;

      // Table of sweeps; the first one starts on the cycle right after
      // reset is released.
      for (int i = 0; i < 6; i++) begin
         applyStimulus(vecs[i]);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
      $finish;
   end

endmodule
